// File: rtl/oled_i2c_stream.sv
`default_nettype none
// ============================================================================
//  Module      : oled_i2c_stream
//  Description : I2C write-only streamer for an OLED panel controller.
//                Opens a transaction while START is high, sends the slave
//                address (write) and then one CMD byte per GAP for as long
//                as START stays high, and closes with a STOP once START
//                drops. Every bus phase lasts DIV CLK cycles; a bit is four
//                phases (P0/P1 SCL low, P2/P3 SCL high).
//  Ports       : CLK          system clock, rising edge
//                ASYNC_RST_L  asynchronous active-low reset
//                CMD[7:0]     next data byte, latched at GAP end
//                START        level request: high holds the transaction open
//                BUSY         a byte (including its ACK bit) is on the bus
//                RUNNING      START condition through end of STOP
//                ACK_ERR      sticky NACK flag, cleared at next START
//                SCL          push-pull I2C clock, idle high
//                SDA          open-drain I2C data (drives 0 or Z only)
//  Revision    : 1.0 - initial release
// ============================================================================
module oled_i2c_stream #(
  parameter int         DIV        = 4,
  parameter logic [6:0] SLAVE_ADDR = 7'h3C
) (
  input  logic       CLK,
  input  logic       ASYNC_RST_L,
  input  logic [7:0] CMD,
  input  logic       START,
  output logic       BUSY,
  output logic       RUNNING,
  output logic       ACK_ERR,
  output logic       SCL,
  inout  wire        SDA
);

  localparam logic [7:0] c_div_m1 = 8'(DIV - 1);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_STA1  = 4'd1,
    S_STA2  = 4'd2,
    S_SHIFT = 4'd3,
    S_ACK   = 4'd4,
    S_GAP   = 4'd5,
    S_STP1  = 4'd6,
    S_STP2  = 4'd7,
    S_STP3  = 4'd8
  } state_t;

  state_t     r_state,   w_state_nxt;
  logic [7:0] r_tick,    w_tick_nxt;
  logic [1:0] r_phase,   w_phase_nxt;
  logic [2:0] r_bit,     w_bit_nxt;
  logic [7:0] r_shift,   w_shift_nxt;
  logic       r_busy,    w_busy_nxt;
  logic       r_running, w_running_nxt;
  logic       r_ack_err, w_ack_err_nxt;
  logic       w_scl;
  logic       w_sda_low;
  logic       w_phase_end;
  logic       w_sda_in;

  assign w_phase_end = (r_tick == c_div_m1);
  assign w_sda_in    = SDA;

  // SCL and SDA are decoded from registered state only, so the reset
  // values (SCL high, SDA released) appear as soon as reset asserts.
  assign SCL     = w_scl;
  assign SDA     = w_sda_low ? 1'b0 : 1'bz;
  assign BUSY    = r_busy;
  assign RUNNING = r_running;
  assign ACK_ERR = r_ack_err;

  always_ff @(posedge CLK or negedge ASYNC_RST_L) begin
    if (!ASYNC_RST_L) begin
      r_state   <= S_IDLE;
      r_tick    <= 8'd0;
      r_phase   <= 2'd0;
      r_bit     <= 3'd0;
      r_shift   <= 8'd0;
      r_busy    <= 1'b0;
      r_running <= 1'b0;
      r_ack_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_tick    <= w_tick_nxt;
      r_phase   <= w_phase_nxt;
      r_bit     <= w_bit_nxt;
      r_shift   <= w_shift_nxt;
      r_busy    <= w_busy_nxt;
      r_running <= w_running_nxt;
      r_ack_err <= w_ack_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_tick_nxt    = w_phase_end ? 8'd0 : r_tick + 8'd1;
    w_phase_nxt   = r_phase;
    w_bit_nxt     = r_bit;
    w_shift_nxt   = r_shift;
    w_busy_nxt    = r_busy;
    w_running_nxt = r_running;
    w_ack_err_nxt = r_ack_err;
    w_scl         = 1'b1;
    w_sda_low     = 1'b0;

    case (r_state)
      S_IDLE: begin
        // Timer held at zero so STA1 always gets a full phase.
        w_tick_nxt = 8'd0;
        if (START) begin
          w_ack_err_nxt = 1'b0;
          w_running_nxt = 1'b1;
          w_state_nxt   = S_STA1;
        end
      end
      S_STA1: begin
        w_sda_low = 1'b1;
        if (w_phase_end) w_state_nxt = S_STA2;
      end
      S_STA2: begin
        w_scl     = 1'b0;
        w_sda_low = 1'b1;
        if (w_phase_end) begin
          w_shift_nxt = {SLAVE_ADDR, 1'b0};
          w_busy_nxt  = 1'b1;
          w_bit_nxt   = 3'd0;
          w_phase_nxt = 2'd0;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // The shift register only moves at a P3->P0 boundary, which keeps
        // SDA constant through the SCL-high half of every bit.
        w_scl     = r_phase[1];
        w_sda_low = ~r_shift[7];
        if (w_phase_end) begin
          if (r_phase == 2'd3) begin
            w_phase_nxt = 2'd0;
            if (r_bit == 3'd7) begin
              w_bit_nxt   = 3'd0;
              w_state_nxt = S_ACK;
            end else begin
              w_bit_nxt   = r_bit + 3'd1;
              w_shift_nxt = {r_shift[6:0], 1'b0};
            end
          end else begin
            w_phase_nxt = r_phase + 2'd1;
          end
        end
      end
      S_ACK: begin
        w_scl = r_phase[1];
        if (w_phase_end) begin
          if (r_phase == 2'd2) begin
            // Sampled on the edge that opens P3, mid SCL-high.
            w_phase_nxt = 2'd3;
            if (w_sda_in) w_ack_err_nxt = 1'b1;
          end else if (r_phase == 2'd3) begin
            w_phase_nxt = 2'd0;
            w_busy_nxt  = 1'b0;
            w_state_nxt = S_GAP;
          end else begin
            w_phase_nxt = r_phase + 2'd1;
          end
        end
      end
      S_GAP: begin
        w_scl     = 1'b0;
        w_sda_low = 1'b1;
        if (w_phase_end) begin
          if (START) begin
            w_shift_nxt = CMD;
            w_busy_nxt  = 1'b1;
            w_bit_nxt   = 3'd0;
            w_phase_nxt = 2'd0;
            w_state_nxt = S_SHIFT;
          end else begin
            w_state_nxt = S_STP1;
          end
        end
      end
      S_STP1: begin
        w_scl     = 1'b0;
        w_sda_low = 1'b1;
        if (w_phase_end) w_state_nxt = S_STP2;
      end
      S_STP2: begin
        w_sda_low = 1'b1;
        if (w_phase_end) w_state_nxt = S_STP3;
      end
      S_STP3: begin
        if (w_phase_end) begin
          w_running_nxt = 1'b0;
          w_state_nxt   = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_oled_i2c_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_oled_i2c_stream
//  Description : Directed self-checking bench for oled_i2c_stream (DIV=4).
//                A bus monitor/slave decodes bytes, START and STOP
//                conditions from SCL/SDA sampled on the falling CLK edge and
//                acknowledges each byte when ack_en is set.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_oled_i2c_stream;

  localparam int W_BUSY = 0;
  localparam int W_RUN  = 1;

  logic       clk = 1'b0;
  logic       rst_l;
  logic [7:0] cmd;
  logic       start;
  wire        busy, running, ack_err, scl;
  wire        sda;

  logic       slave_drv = 1'b0;
  logic       ack_en    = 1'b1;

  pullup (sda);
  assign sda = slave_drv ? 1'b0 : 1'bz;

  oled_i2c_stream #(.DIV(4), .SLAVE_ADDR(7'h3C)) dut (
    .CLK        (clk),
    .ASYNC_RST_L(rst_l),
    .CMD        (cmd),
    .START      (start),
    .BUSY       (busy),
    .RUNNING    (running),
    .ACK_ERR    (ack_err),
    .SCL        (scl),
    .SDA        (sda)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- bus monitor / slave ----------------
  logic       prev_scl  = 1'b1;
  logic       prev_sda  = 1'b1;
  logic [7:0] sh        = 8'd0;
  int         bitcnt    = 0;
  int         start_cnt = 0;
  int         stop_cnt  = 0;
  int         scl_edges = 0;
  logic [7:0] byte_q[$];

  always @(negedge clk) begin
    if (prev_scl && scl && prev_sda && !sda) begin
      start_cnt <= start_cnt + 1;
      bitcnt    <= 0;
      slave_drv <= 1'b0;
    end else if (prev_scl && scl && !prev_sda && sda) begin
      stop_cnt <= stop_cnt + 1;
    end else if (!prev_scl && scl) begin
      if (bitcnt < 8) sh <= {sh[6:0], sda};
      bitcnt <= bitcnt + 1;
    end else if (prev_scl && !scl) begin
      if (bitcnt == 8) begin
        slave_drv <= ack_en;
      end else if (bitcnt == 9) begin
        slave_drv <= 1'b0;
        byte_q.push_back(sh);
        bitcnt <= 0;
      end
    end
    if (prev_scl != scl) scl_edges <= scl_edges + 1;
    prev_scl <= scl;
    prev_sda <= sda;
  end

  // ---------------- helpers ----------------
  function automatic logic sig(input int which);
    return (which == W_BUSY) ? busy : running;
  endfunction

  task automatic wait_for(input int which, input logic val);
    int n;
    n = 0;
    while (sig(which) !== val && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (sig(which) !== val) begin
      checks++;
      errors++;
      $display("FAIL wait_sig%0d got %b expected %b (timeout)", which, sig(which), val);
    end
  endtask

  task automatic hold_count(input int which, input logic val, output int n);
    n = 0;
    while (sig(which) === val && n < 2000) begin
      @(negedge clk);
      n++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    int e0;
    rst_l = 1'b0;
    start = 1'b0;
    cmd   = 8'h00;
    repeat (3) @(negedge clk);
    checks++; if (scl !== 1'b1)     begin errors++; $display("FAIL rst_scl got %b expected 1", scl); end
    checks++; if (sda !== 1'b1)     begin errors++; $display("FAIL rst_sda got %b expected 1", sda); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL rst_busy got %b expected 0", busy); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL rst_running got %b expected 0", running); end
    checks++; if (ack_err !== 1'b0) begin errors++; $display("FAIL rst_ack_err got %b expected 0", ack_err); end
    e0 = scl_edges;
    rst_l = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL idle_running got %b expected 0", running); end
    checks++; if (scl_edges !== e0) begin errors++; $display("FAIL idle_scl_edges got %0d expected %0d", scl_edges, e0); end
  endtask

  task automatic test_stream;
    int n, qb, s0, p0;
    logic [7:0] exp_b [2];
    exp_b[0] = 8'h78; exp_b[1] = 8'hAF;
    qb = byte_q.size(); s0 = start_cnt; p0 = stop_cnt;
    cmd = 8'hAF; start = 1'b1;
    wait_for(W_BUSY, 1'b1);
    hold_count(W_BUSY, 1'b1, n);
    checks++; if (n != 144) begin errors++; $display("FAIL addr_busy_len got %0d expected 144", n); end
    hold_count(W_BUSY, 1'b0, n);
    checks++; if (n != 4) begin errors++; $display("FAIL gap_len got %0d expected 4", n); end
    repeat (10) @(negedge clk);
    start = 1'b0;
    hold_count(W_BUSY, 1'b1, n);
    checks++; if (n != 134) begin errors++; $display("FAIL data_busy_rest got %0d expected 134", n); end
    wait_for(W_RUN, 1'b0);
    checks++; if (ack_err !== 1'b0) begin errors++; $display("FAIL stream_ack_err got %b expected 0", ack_err); end
    checks++;
    if (byte_q.size() - qb != 2) begin
      errors++; $display("FAIL stream_nbytes got %0d expected 2", byte_q.size() - qb);
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (byte_q[qb+i] !== exp_b[i]) begin errors++; $display("FAIL stream_byte%0d got %h expected %h", i, byte_q[qb+i], exp_b[i]); end
      end
    end
    checks++; if (start_cnt - s0 != 1) begin errors++; $display("FAIL stream_starts got %0d expected 1", start_cnt - s0); end
    checks++; if (stop_cnt - p0 != 1)  begin errors++; $display("FAIL stream_stops got %0d expected 1", stop_cnt - p0); end
  endtask

  task automatic test_stop;
    int n, qb, p0;
    logic [7:0] exp_b [3];
    exp_b[0] = 8'h78; exp_b[1] = 8'hAF; exp_b[2] = 8'h40;
    qb = byte_q.size(); p0 = stop_cnt;
    cmd = 8'hAF; start = 1'b1;
    wait_for(W_BUSY, 1'b1);
    wait_for(W_BUSY, 1'b0);
    wait_for(W_BUSY, 1'b1);
    cmd = 8'h40;
    wait_for(W_BUSY, 1'b0);
    wait_for(W_BUSY, 1'b1);
    repeat (40) @(negedge clk);
    start = 1'b0;
    cmd   = 8'hFF;
    hold_count(W_BUSY, 1'b1, n);
    checks++; if (n != 104) begin errors++; $display("FAIL stop_byte_complete got %0d expected 104", n); end
    hold_count(W_RUN, 1'b1, n);
    checks++; if (n != 16) begin errors++; $display("FAIL stop_running_fall got %0d expected 16", n); end
    checks++;
    if (byte_q.size() - qb != 3) begin
      errors++; $display("FAIL stop_nbytes got %0d expected 3", byte_q.size() - qb);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (byte_q[qb+i] !== exp_b[i]) begin errors++; $display("FAIL stop_byte%0d got %h expected %h", i, byte_q[qb+i], exp_b[i]); end
      end
    end
    checks++; if (stop_cnt - p0 != 1) begin errors++; $display("FAIL stop_seen got %0d expected 1", stop_cnt - p0); end
    checks++; if (scl !== 1'b1 || sda !== 1'b1) begin errors++; $display("FAIL stop_idle_bus got scl=%b sda=%b expected 1/1", scl, sda); end
  endtask

  task automatic test_nack;
    int qb;
    qb = byte_q.size();
    ack_en = 1'b0;
    cmd = 8'h00; start = 1'b1;
    wait_for(W_BUSY, 1'b1);
    wait_for(W_BUSY, 1'b0);
    checks++; if (ack_err !== 1'b1) begin errors++; $display("FAIL nack_flag got %b expected 1", ack_err); end
    ack_en = 1'b1;
    wait_for(W_BUSY, 1'b1);
    start = 1'b0;
    wait_for(W_RUN, 1'b0);
    checks++; if (ack_err !== 1'b1) begin errors++; $display("FAIL nack_sticky got %b expected 1", ack_err); end
    checks++;
    if (byte_q.size() - qb != 2) begin
      errors++; $display("FAIL nack_nbytes got %0d expected 2", byte_q.size() - qb);
    end else begin
      checks++; if (byte_q[qb] !== 8'h78)   begin errors++; $display("FAIL nack_addr got %h expected 78", byte_q[qb]); end
      checks++; if (byte_q[qb+1] !== 8'h00) begin errors++; $display("FAIL nack_data got %h expected 00", byte_q[qb+1]); end
    end
    start = 1'b1;
    @(negedge clk);
    checks++; if (ack_err !== 1'b0) begin errors++; $display("FAIL nack_clear got %b expected 0", ack_err); end
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL nack_restart got %b expected 1", running); end
    start = 1'b0;
    wait_for(W_RUN, 1'b0);
    checks++; if (ack_err !== 1'b0) begin errors++; $display("FAIL nack_clean_txn got %b expected 0", ack_err); end
  endtask

  task automatic test_reset_mid;
    int e0;
    cmd = 8'hA5; start = 1'b1;
    wait_for(W_BUSY, 1'b1);
    wait_for(W_BUSY, 1'b0);
    wait_for(W_BUSY, 1'b1);
    repeat (50) @(negedge clk);
    #2 rst_l = 1'b0;
    #1;
    checks++; if (scl !== 1'b1)     begin errors++; $display("FAIL midrst_scl got %b expected 1", scl); end
    checks++; if (sda !== 1'b1)     begin errors++; $display("FAIL midrst_sda got %b expected 1", sda); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL midrst_busy got %b expected 0", busy); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL midrst_running got %b expected 0", running); end
    start = 1'b0;
    repeat (3) @(negedge clk);
    e0 = scl_edges;
    rst_l = 1'b1;
    repeat (200) @(negedge clk);
    checks++; if (scl_edges != e0)  begin errors++; $display("FAIL midrst_scl_edges got %0d expected %0d", scl_edges, e0); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL midrst_no_txn got %b expected 0", running); end
  endtask

  task automatic test_back_to_back;
    int qb, s0, p0;
    logic [7:0] exp_b [3];
    exp_b[0] = 8'h78; exp_b[1] = 8'h3C; exp_b[2] = 8'h78;
    qb = byte_q.size(); s0 = start_cnt; p0 = stop_cnt;
    cmd = 8'h3C; start = 1'b1;
    wait_for(W_BUSY, 1'b1);
    wait_for(W_BUSY, 1'b0);
    wait_for(W_BUSY, 1'b1);
    start = 1'b0;
    wait_for(W_RUN, 1'b0);
    start = 1'b1;
    @(negedge clk);
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL b2b_running got %b expected 1", running); end
    checks++; if (scl !== 1'b1 || sda !== 1'b0) begin errors++; $display("FAIL b2b_sta got scl=%b sda=%b expected 1/0", scl, sda); end
    wait_for(W_BUSY, 1'b1);
    start = 1'b0;
    wait_for(W_BUSY, 1'b0);
    wait_for(W_RUN, 1'b0);
    checks++;
    if (byte_q.size() - qb != 3) begin
      errors++; $display("FAIL b2b_nbytes got %0d expected 3", byte_q.size() - qb);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (byte_q[qb+i] !== exp_b[i]) begin errors++; $display("FAIL b2b_byte%0d got %h expected %h", i, byte_q[qb+i], exp_b[i]); end
      end
    end
    checks++; if (start_cnt - s0 != 2) begin errors++; $display("FAIL b2b_starts got %0d expected 2", start_cnt - s0); end
    checks++; if (stop_cnt - p0 != 2)  begin errors++; $display("FAIL b2b_stops got %0d expected 2", stop_cnt - p0); end
    checks++; if (ack_err !== 1'b0)    begin errors++; $display("FAIL b2b_ack_err got %b expected 0", ack_err); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_l = 1'b0;
    start = 1'b0;
    cmd   = 8'h00;
    @(negedge clk);
    test_reset();
    test_stream();
    test_stop();
    test_nack();
    test_reset_mid();
    test_back_to_back();
    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/oled_i2c_stream.md
OLED_I2C_STREAM -- requirements
Module: oled_i2c_stream

Interface
REQ-001 SHALL have parameter DIV, default 4: CLK cycles per SCL quarter-period, legal range 1..255.
REQ-002 SHALL have parameter SLAVE_ADDR, default 7'h3C: 7-bit I2C address of the panel controller.
REQ-003 SHALL have port CLK, input, 1, system clock; all state changes occur on its rising edge.
REQ-004 SHALL have port ASYNC_RST_L, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port CMD, input, 8, next byte to transmit; sampled only at byte load.
REQ-006 SHALL have port START, input, 1, level request: high opens and holds a transaction, low closes it.
REQ-007 SHALL have port BUSY, output, 1, high while a byte (address or data) is being shifted, including its ACK bit.
REQ-008 SHALL have port RUNNING, output, 1, high from the START condition through completion of the STOP condition.
REQ-009 SHALL have port ACK_ERR, output, 1, sticky flag set on any NACK.
REQ-010 SHALL have port SCL, output, 1, I2C clock, push-pull, idle high.
REQ-011 SHALL have port SDA, inout, 1, open-drain: drives 0 or high-Z, never drives 1.

Function
REQ-012 SHALL use a quarter-phase timer: every phase lasts exactly DIV CLK cycles; a bit is 4 phases (P0/P1 SCL low, P2/P3 SCL high).
REQ-013 SHALL change SDA only at the start of P0 of each data bit; SDA stays stable while SCL is high.
REQ-014 SHALL implement states IDLE, STA1, STA2, SHIFT, ACK, GAP, STP1, STP2, STP3.
REQ-015 In IDLE, when START=1: SHALL clear ACK_ERR, raise RUNNING, and enter STA1; START=0 keeps IDLE.
REQ-016 STA1 (one phase): SHALL hold SCL=1 and pull SDA low; STA2 (one phase): SHALL pull SCL low.
REQ-017 After STA2: SHALL load {SLAVE_ADDR,1'b0}, raise BUSY, and enter SHIFT.
REQ-018 SHIFT: SHALL send 8 bits MSB first, then enter ACK.
REQ-019 ACK: SHALL release SDA for one bit, sample SDA at the start of P3, and set ACK_ERR if SDA=1.
REQ-020 SHALL continue the transaction after a NACK; the NACK only sets ACK_ERR.
REQ-021 At the end of ACK: SHALL drop BUSY, hold SCL low, hold SDA low, and enter GAP for exactly one phase.
REQ-022 At the end of GAP with START=1: SHALL latch CMD, raise BUSY, and enter SHIFT.
REQ-023 At the end of GAP with START=0: SHALL enter STP1.
REQ-024 A START deassertion during SHIFT or ACK SHALL NOT abort the byte; it is honoured at the next GAP end.
REQ-025 STP1/STP2/STP3, one phase each: STP1 SHALL hold SCL=0, SDA=0; STP2 SHALL raise SCL=1; STP3 SHALL release SDA.
REQ-026 After STP3: SHALL drop RUNNING and return to IDLE.
REQ-027 START=1 at IDLE re-entry SHALL begin a new transaction on the next cycle.
REQ-028 Per-byte time, GAP excluded, SHALL be 36*DIV CLK cycles; each GAP SHALL be DIV cycles.
REQ-029 CMD changes outside the GAP-end sample cycle SHALL have no effect.
REQ-030 Bit and phase counters SHALL wrap only via explicit state transitions; no free-running overflow SHALL affect output.

Reset
REQ-031 While ASYNC_RST_L=0: SHALL force SCL=1, SDA high-Z, BUSY=0, RUNNING=0, ACK_ERR=0, state IDLE, and all counters and the shift register to 0, immediately and asynchronously.
REQ-032 Reset asserted mid-byte SHALL abandon the transfer with no STOP generated.
REQ-033 After release: SHALL start no transaction until START is sampled high in IDLE.

Verification
REQ-034 DIV=4, START held, CMD=8'hAF, slave ACKs all -> STA; bus shows 8'h78 then 8'hAF; each byte 144 cycles; BUSY low for 4 cycles between bytes; ACK_ERR=0.
REQ-035 START dropped during the 2nd data byte (8'h40) -> 8'h40 completes fully; STOP follows (SCL rises before SDA); RUNNING falls 12 cycles after GAP end.
REQ-036 Address NACK (SDA floats high) -> ACK_ERR=1, data byte 8'h00 still sent; ACK_ERR clears at the next START.
REQ-037 Reset pulsed at bit 3 of a data byte -> SCL=1, SDA=Z, BUSY=0, RUNNING=0 within the same cycle; no further SCL edges.
REQ-038 Back-to-back transactions, START re-asserted in the cycle RUNNING falls -> new STA begins on the next cycle with a correct address byte.
REQ-039 Every check -> SDA never driven to 1, and SDA never changes while SCL=1 except during STA and STOP.
